// File: rtl/stream_switch.sv
// ============================================================================
// Module   : stream_switch
// Brief    : CGRA tile switch - XY config routing, operand gather, PE fire,
//            result broadcast to a port mask. Port index: 0=S 1=E 2=N 3=W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_switch #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int HX_W   = 4,
   parameter int HY_W   = 4,
   parameter int CFG_W  = HX_W + HY_W + 14 + OP_W + DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_n_valid,
   output logic                  cfg_n_ready,
   input  logic [CFG_W-1:0]      cfg_n_data,
   input  logic                  cfg_w_valid,
   output logic                  cfg_w_ready,
   input  logic [CFG_W-1:0]      cfg_w_data,
   output logic                  cfg_e_valid,
   input  logic                  cfg_e_ready,
   output logic [CFG_W-1:0]      cfg_e_data,
   output logic                  cfg_s_valid,
   input  logic                  cfg_s_ready,
   output logic [CFG_W-1:0]      cfg_s_data,
   input  logic [3:0]            in_valid,
   output logic [3:0]            in_ready,
   input  logic [4*DATA_W-1:0]   in_data,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic [4*DATA_W-1:0]   out_data,
   output logic                  pe_go,
   output logic [OP_W-1:0]       pe_op,
   output logic [DATA_W-1:0]     pe_imm,
   output logic [DATA_W-1:0]     pe_a,
   output logic [DATA_W-1:0]     pe_b,
   output logic [DATA_W-1:0]     pe_c,
   input  logic                  pe_done,
   input  logic [DATA_W-1:0]     pe_result,
   output logic                  configured
);

   localparam int c_OP_LSB    = DATA_W;
   localparam int c_NOPS_LSB  = DATA_W + OP_W + 4;
   localparam int c_OMASK_LSB = c_NOPS_LSB + 2;
   localparam int c_SEL_LSB   = c_OMASK_LSB + 4;
   localparam int c_HY_LSB    = c_SEL_LSB + 4;
   localparam int c_HX_LSB    = c_HY_LSB + HY_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GATHER = 3'd1,
      S_FIRE   = 3'd2,
      S_WAIT   = 3'd3,
      S_BCAST  = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_e_valid, r_s_valid;
   logic [CFG_W-1:0]    r_e_data, r_s_data;
   logic [3:0]          r_sel, r_omask, r_out_valid;
   logic [1:0]          r_nops, r_slot, r_port;
   logic [OP_W-1:0]     r_op;
   logic [DATA_W-1:0]   r_imm, r_a, r_b, r_c, r_result;
   logic                r_pe_go, r_configured;

   // Next selected port strictly after cur, wrapping; cur itself is the last candidate.
   function automatic logic [1:0] f_next_port(input logic [3:0] sel, input logic [1:0] cur);
      logic [1:0] idx;
      logic       found;
      f_next_port = cur;
      found       = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = cur + 2'(i);
         if (!found && sel[idx]) begin
            f_next_port = idx;
            found       = 1'b1;
         end
      end
   endfunction

   logic w_n_east, w_n_south, w_w_east, w_w_south;
   logic w_e_free, w_s_free, w_local_ok, w_n_ok, w_w_ok;
   logic w_take_n, w_take_w, w_to_east, w_to_south, w_local_load;
   logic [CFG_W-1:0] w_pkt, w_fwd_e, w_fwd_s;

   assign w_n_east   = |cfg_n_data[c_HX_LSB +: HX_W];
   assign w_n_south  = !w_n_east && (|cfg_n_data[c_HY_LSB +: HY_W]);
   assign w_w_east   = |cfg_w_data[c_HX_LSB +: HX_W];
   assign w_w_south  = !w_w_east && (|cfg_w_data[c_HY_LSB +: HY_W]);
   assign w_e_free   = !r_e_valid || cfg_e_ready;
   assign w_s_free   = !r_s_valid || cfg_s_ready;
   assign w_local_ok = (r_state == S_IDLE) || (r_state == S_GATHER);
   assign w_n_ok     = w_n_east ? w_e_free : (w_n_south ? w_s_free : w_local_ok);
   assign w_w_ok     = w_w_east ? w_e_free : (w_w_south ? w_s_free : w_local_ok);

   assign cfg_n_ready = !reset && w_n_ok;
   assign cfg_w_ready = !reset && !cfg_n_valid && w_w_ok;
   assign w_take_n    = cfg_n_valid && cfg_n_ready;
   assign w_take_w    = cfg_w_valid && cfg_w_ready;
   assign w_pkt       = w_take_n ? cfg_n_data : cfg_w_data;
   assign w_to_east   = (w_take_n && w_n_east) || (w_take_w && w_w_east);
   assign w_to_south  = (w_take_n && w_n_south) || (w_take_w && w_w_south);
   assign w_local_load = (w_take_n && !w_n_east && !w_n_south) ||
                         (w_take_w && !w_w_east && !w_w_south);

   always_comb begin
      w_fwd_e = w_pkt;
      w_fwd_s = w_pkt;
      w_fwd_e[c_HX_LSB +: HX_W] = w_pkt[c_HX_LSB +: HX_W] - HX_W'(1);
      w_fwd_s[c_HY_LSB +: HY_W] = w_pkt[c_HY_LSB +: HY_W] - HY_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_e_valid <= 1'b0;
         r_e_data  <= '0;
         r_s_valid <= 1'b0;
         r_s_data  <= '0;
      end else begin
         if (w_to_east) begin
            r_e_valid <= 1'b1;
            r_e_data  <= w_fwd_e;
         end else if (cfg_e_ready) begin
            r_e_valid <= 1'b0;
         end
         if (w_to_south) begin
            r_s_valid <= 1'b1;
            r_s_data  <= w_fwd_s;
         end else if (cfg_s_ready) begin
            r_s_valid <= 1'b0;
         end
      end
   end

   assign cfg_e_valid = r_e_valid;
   assign cfg_e_data  = r_e_data;
   assign cfg_s_valid = r_s_valid;
   assign cfg_s_data  = r_s_data;

   // A local load in the same cycle wins over an operand, so the operand is never offered.
   logic               w_gather_rdy, w_in_hs;
   logic [DATA_W-1:0]  w_lane [4];
   logic [DATA_W-1:0]  w_operand;

   assign w_gather_rdy = (r_state == S_GATHER) && (r_nops != 2'd0) &&
                         (r_sel != 4'd0) && !w_local_load;

   generate
      for (genvar p = 0; p < 4; p++) begin : g_in_port
         assign w_lane[p]   = in_data[p*DATA_W +: DATA_W];
         assign in_ready[p] = w_gather_rdy && (r_port == 2'(p));
      end
   endgenerate

   assign w_operand = w_lane[r_port];
   assign w_in_hs   = w_gather_rdy && in_valid[r_port];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_sel        <= 4'd0;
         r_omask      <= 4'd0;
         r_nops       <= 2'd0;
         r_op         <= '0;
         r_imm        <= '0;
         r_slot       <= 2'd0;
         r_port       <= 2'd0;
         r_a          <= '0;
         r_b          <= '0;
         r_c          <= '0;
         r_result     <= '0;
         r_out_valid  <= 4'd0;
         r_pe_go      <= 1'b0;
         r_configured <= 1'b0;
      end else if (w_local_load) begin
         r_sel        <= w_pkt[c_SEL_LSB +: 4];
         r_omask      <= w_pkt[c_OMASK_LSB +: 4];
         r_nops       <= w_pkt[c_NOPS_LSB +: 2];
         r_op         <= w_pkt[c_OP_LSB +: OP_W];
         r_imm        <= w_pkt[DATA_W-1:0];
         r_slot       <= 2'd0;
         r_port       <= f_next_port(w_pkt[c_SEL_LSB +: 4], 2'd3);
         r_a          <= '0;
         r_b          <= '0;
         r_c          <= '0;
         r_configured <= 1'b1;
         r_state      <= S_GATHER;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_GATHER: begin
               if (r_nops == 2'd0) begin
                  r_result <= r_imm;
                  if (r_omask != 4'd0) begin
                     r_out_valid <= r_omask;
                     r_state     <= S_BCAST;
                  end
               end else if (w_in_hs) begin
                  case (r_slot)
                     2'd0:    r_a <= w_operand;
                     2'd1:    r_b <= w_operand;
                     default: r_c <= w_operand;
                  endcase
                  if (r_slot == r_nops - 2'd1) begin
                     r_pe_go <= 1'b1;
                     r_state <= S_FIRE;
                  end else begin
                     r_slot <= r_slot + 2'd1;
                     r_port <= f_next_port(r_sel, r_port);
                  end
               end
            end
            S_FIRE: begin
               r_pe_go <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (pe_done) begin
                  r_result <= pe_result;
                  if (r_omask == 4'd0) begin
                     r_slot  <= 2'd0;
                     r_port  <= f_next_port(r_sel, 2'd3);
                     r_a     <= '0;
                     r_b     <= '0;
                     r_c     <= '0;
                     r_state <= S_GATHER;
                  end else begin
                     r_out_valid <= r_omask;
                     r_state     <= S_BCAST;
                  end
               end
            end
            S_BCAST: begin
               r_out_valid <= r_out_valid & ~out_ready;
               if ((r_out_valid & ~out_ready) == 4'd0) begin
                  if (r_nops == 2'd0) begin
                     r_out_valid <= r_omask;
                  end else begin
                     r_slot  <= 2'd0;
                     r_port  <= f_next_port(r_sel, 2'd3);
                     r_a     <= '0;
                     r_b     <= '0;
                     r_c     <= '0;
                     r_state <= S_GATHER;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = {4{r_result}};
   assign pe_go      = r_pe_go;
   assign pe_op      = r_op;
   assign pe_imm     = r_imm;
   assign pe_a       = r_a;
   assign pe_b       = r_b;
   assign pe_c       = r_c;
   assign configured = r_configured;

endmodule

`default_nettype wire

// File: tb/tb_stream_switch.sv
// ============================================================================
// Module   : tb_stream_switch
// Brief    : Directed self-checking bench for stream_switch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_switch;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam int HX_W   = 4;
   localparam int HY_W   = 4;
   localparam int CFG_W  = HX_W + HY_W + 14 + OP_W + DATA_W;

   logic                clk, reset;
   logic                cfg_n_valid, cfg_n_ready, cfg_w_valid, cfg_w_ready;
   logic                cfg_e_valid, cfg_e_ready, cfg_s_valid, cfg_s_ready;
   logic [CFG_W-1:0]    cfg_n_data, cfg_w_data, cfg_e_data, cfg_s_data;
   logic [3:0]          in_valid, in_ready, out_valid, out_ready;
   logic [4*DATA_W-1:0] in_data, out_data;
   logic                pe_go, pe_done, configured;
   logic [OP_W-1:0]     pe_op;
   logic [DATA_W-1:0]   pe_imm, pe_a, pe_b, pe_c, pe_result;

   int pass_cnt  = 0;
   int total_cnt = 0;

   stream_switch #(.DATA_W(DATA_W), .OP_W(OP_W), .HX_W(HX_W), .HY_W(HY_W), .CFG_W(CFG_W)) dut (
      .clk(clk), .reset(reset),
      .cfg_n_valid(cfg_n_valid), .cfg_n_ready(cfg_n_ready), .cfg_n_data(cfg_n_data),
      .cfg_w_valid(cfg_w_valid), .cfg_w_ready(cfg_w_ready), .cfg_w_data(cfg_w_data),
      .cfg_e_valid(cfg_e_valid), .cfg_e_ready(cfg_e_ready), .cfg_e_data(cfg_e_data),
      .cfg_s_valid(cfg_s_valid), .cfg_s_ready(cfg_s_ready), .cfg_s_data(cfg_s_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .pe_go(pe_go), .pe_op(pe_op), .pe_imm(pe_imm),
      .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c),
      .pe_done(pe_done), .pe_result(pe_result), .configured(configured)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CFG_W-1:0] mk_pkt(input logic [3:0] hx, input logic [3:0] hy,
                                                input logic [3:0] sel, input logic [3:0] omask,
                                                input logic [1:0] nops, input logic [3:0] op,
                                                input logic [31:0] imm);
      return {hx, hy, sel, omask, nops, 4'b0000, op, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cfg_n_valid = 0; cfg_w_valid = 0; cfg_n_data = '0; cfg_w_data = '0;
      cfg_e_ready = 0; cfg_s_ready = 0; in_valid = 0; in_data = '0;
      out_ready = 0; pe_done = 0; pe_result = '0;
      tick(); tick();
      total_cnt++; if (out_valid !== 4'd0) $display("FAIL reset_out_valid got=%b exp=0000", out_valid); else pass_cnt++;
      total_cnt++; if ({cfg_e_valid, cfg_s_valid} !== 2'b00) $display("FAIL reset_cfg_valid got=%b exp=00", {cfg_e_valid, cfg_s_valid}); else pass_cnt++;
      total_cnt++; if ({configured, pe_go} !== 2'b00) $display("FAIL reset_cfg_go got=%b exp=00", {configured, pe_go}); else pass_cnt++;
      total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else pass_cnt++;
      reset = 1'b0;
      tick();
      settle();
      total_cnt++; if (in_ready !== 4'd0) $display("FAIL idle_in_ready got=%b exp=0000", in_ready); else pass_cnt++;
   endtask

   task automatic test_route();
      cfg_n_valid = 1; cfg_n_data = mk_pkt(4'd2, 4'd1, 4'd0, 4'd0, 2'd0, 4'd0, 32'hA5);
      settle();
      total_cnt++; if (cfg_n_ready !== 1'b1) $display("FAIL route_n_ready_empty got=%b exp=1", cfg_n_ready); else pass_cnt++;
      tick();
      cfg_n_data = mk_pkt(4'd1, 4'd0, 4'd0, 4'd0, 2'd0, 4'd0, 32'h5A);
      settle();
      total_cnt++; if (cfg_e_valid !== 1'b1) $display("FAIL route_e_valid got=%b exp=1", cfg_e_valid); else pass_cnt++;
      total_cnt++; if (cfg_e_data !== mk_pkt(4'd1, 4'd1, 4'd0, 4'd0, 2'd0, 4'd0, 32'hA5)) $display("FAIL route_e_data got=%h exp=%h", cfg_e_data, mk_pkt(4'd1, 4'd1, 4'd0, 4'd0, 2'd0, 4'd0, 32'hA5)); else pass_cnt++;
      total_cnt++; if (cfg_n_ready !== 1'b0) $display("FAIL route_n_ready_full got=%b exp=0", cfg_n_ready); else pass_cnt++;
      tick();
      total_cnt++; if (cfg_e_data !== mk_pkt(4'd1, 4'd1, 4'd0, 4'd0, 2'd0, 4'd0, 32'hA5)) $display("FAIL route_e_held got=%h", cfg_e_data); else pass_cnt++;
      cfg_e_ready = 1;
      settle();
      total_cnt++; if (cfg_n_ready !== 1'b1) $display("FAIL route_n_ready_drain got=%b exp=1", cfg_n_ready); else pass_cnt++;
      tick();
      cfg_n_valid = 0;
      total_cnt++; if (cfg_e_data !== mk_pkt(4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 4'd0, 32'h5A)) $display("FAIL route_e_second got=%h", cfg_e_data); else pass_cnt++;
      tick();
      total_cnt++; if (cfg_e_valid !== 1'b0) $display("FAIL route_e_drained got=%b exp=0", cfg_e_valid); else pass_cnt++;
      cfg_s_ready = 1;
      cfg_w_valid = 1; cfg_w_data = mk_pkt(4'd0, 4'd3, 4'd0, 4'd0, 2'd0, 4'd0, 32'd77);
      settle();
      total_cnt++; if (cfg_w_ready !== 1'b1) $display("FAIL route_w_ready got=%b exp=1", cfg_w_ready); else pass_cnt++;
      tick();
      cfg_w_valid = 0;
      total_cnt++; if ({cfg_s_valid, cfg_s_data} !== {1'b1, mk_pkt(4'd0, 4'd2, 4'd0, 4'd0, 2'd0, 4'd0, 32'd77)}) $display("FAIL route_s_data got=%b/%h", cfg_s_valid, cfg_s_data); else pass_cnt++;
      tick();
      total_cnt++; if ({cfg_s_valid, configured} !== 2'b00) $display("FAIL route_s_done got=%b exp=00", {cfg_s_valid, configured}); else pass_cnt++;
   endtask

   task automatic test_local();
      cfg_n_valid = 1; cfg_n_data = mk_pkt(4'd0, 4'd0, 4'b0101, 4'b0011, 2'd2, 4'd3, 32'd7);
      tick();
      cfg_n_valid = 0;
      total_cnt++; if ({configured, pe_op, pe_imm} !== {1'b1, 4'd3, 32'd7}) $display("FAIL local_load got=%b/%0d/%0d", configured, pe_op, pe_imm); else pass_cnt++;
      in_data[0*DATA_W +: DATA_W] = 32'd10;
      in_data[2*DATA_W +: DATA_W] = 32'd20;
      in_valid = 4'b0101;
      settle();
      total_cnt++; if (in_ready !== 4'b0001) $display("FAIL local_ready_s got=%b exp=0001", in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (in_ready !== 4'b0100) $display("FAIL local_ready_n got=%b exp=0100", in_ready); else pass_cnt++;
      tick();
      in_valid = 0;
      total_cnt++; if ({pe_go, pe_op} !== {1'b1, 4'd3}) $display("FAIL local_fire got=%b/%0d", pe_go, pe_op); else pass_cnt++;
      total_cnt++; if ({pe_a, pe_b, pe_c} !== {32'd10, 32'd20, 32'd0}) $display("FAIL local_operands got=%0d/%0d/%0d exp=10/20/0", pe_a, pe_b, pe_c); else pass_cnt++;
      tick();
      total_cnt++; if ({pe_go, pe_a} !== {1'b0, 32'd10}) $display("FAIL local_wait got=%b/%0d", pe_go, pe_a); else pass_cnt++;
      pe_done = 1; pe_result = 32'd30;
      tick();
      pe_done = 0;
      total_cnt++; if (out_valid !== 4'b0011) $display("FAIL local_out_valid got=%b exp=0011", out_valid); else pass_cnt++;
      total_cnt++; if (out_data[63:0] !== {32'd30, 32'd30}) $display("FAIL local_out_data got=%h", out_data[63:0]); else pass_cnt++;
   endtask

   task automatic test_bcast_stall();
      out_ready = 4'b0001;
      tick();
      total_cnt++; if (out_valid !== 4'b0010) $display("FAIL bcast_lane0_drop got=%b exp=0010", out_valid); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (out_valid !== 4'b0010) $display("FAIL bcast_lane1_held got=%b exp=0010", out_valid); else pass_cnt++;
      out_ready = 4'b0010;
      tick();
      out_ready = 0;
      settle();
      total_cnt++; if ({out_valid, in_ready} !== {4'b0000, 4'b0001}) $display("FAIL bcast_to_gather got=%b/%b", out_valid, in_ready); else pass_cnt++;
      pe_done = 1; pe_result = 32'd99;
      tick();
      pe_done = 0;
      tick();
      total_cnt++; if ({out_valid, pe_go} !== 5'b00000) $display("FAIL bcast_done_ignored got=%b/%b", out_valid, pe_go); else pass_cnt++;
   endtask

   task automatic test_wrap();
      cfg_n_valid = 1; cfg_n_data = mk_pkt(4'd0, 4'd0, 4'b1000, 4'b1000, 2'd2, 4'd5, 32'd0);
      tick();
      cfg_n_valid = 0;
      in_valid = 4'b1111;
      in_data[3*DATA_W +: DATA_W] = 32'd5;
      settle();
      total_cnt++; if (in_ready !== 4'b1000) $display("FAIL wrap_ready_first got=%b exp=1000", in_ready); else pass_cnt++;
      tick();
      in_data[3*DATA_W +: DATA_W] = 32'd9;
      settle();
      total_cnt++; if (in_ready !== 4'b1000) $display("FAIL wrap_ready_second got=%b exp=1000", in_ready); else pass_cnt++;
      tick();
      in_valid = 0;
      total_cnt++; if ({pe_go, pe_op, pe_a, pe_b} !== {1'b1, 4'd5, 32'd5, 32'd9}) $display("FAIL wrap_fire got=%b/%0d/%0d/%0d exp=1/5/5/9", pe_go, pe_op, pe_a, pe_b); else pass_cnt++;
      tick();
      pe_done = 1; pe_result = 32'd14;
      tick();
      pe_done = 0;
      total_cnt++; if ({out_valid, out_data[127:96]} !== {4'b1000, 32'd14}) $display("FAIL wrap_bcast got=%b/%0d", out_valid, out_data[127:96]); else pass_cnt++;
      out_ready = 4'b1000;
      tick();
      out_ready = 0;
      total_cnt++; if (out_valid !== 4'b0000) $display("FAIL wrap_bcast_done got=%b exp=0000", out_valid); else pass_cnt++;
   endtask

   task automatic test_const_and_reset();
      cfg_n_valid = 1; cfg_n_data = mk_pkt(4'd0, 4'd0, 4'b0000, 4'b0100, 2'd0, 4'd9, 32'd42);
      tick();
      cfg_n_valid = 0;
      tick();
      total_cnt++; if ({out_valid, out_data[95:64]} !== {4'b0100, 32'd42}) $display("FAIL const_bcast got=%b/%0d", out_valid, out_data[95:64]); else pass_cnt++;
      cfg_n_valid = 1; cfg_n_data = mk_pkt(4'd0, 4'd0, 4'b0001, 4'b0001, 2'd1, 4'd1, 32'd1);
      settle();
      total_cnt++; if (cfg_n_ready !== 1'b0) $display("FAIL const_local_blocked got=%b exp=0", cfg_n_ready); else pass_cnt++;
      cfg_e_ready = 0;
      cfg_n_data = mk_pkt(4'd1, 4'd0, 4'd0, 4'd0, 2'd0, 4'd0, 32'd33);
      settle();
      total_cnt++; if (cfg_n_ready !== 1'b1) $display("FAIL const_fwd_ready got=%b exp=1", cfg_n_ready); else pass_cnt++;
      out_ready = 4'b0100;
      tick();
      cfg_n_valid = 0; out_ready = 0;
      total_cnt++; if ({out_valid, cfg_e_valid} !== {4'b0100, 1'b1}) $display("FAIL const_repeat got=%b/%b", out_valid, cfg_e_valid); else pass_cnt++;
      reset = 1'b1;
      settle();
      total_cnt++; if ({out_valid, cfg_e_valid, cfg_s_valid, configured} !== 7'd0) $display("FAIL async_reset got=%b/%b/%b/%b", out_valid, cfg_e_valid, cfg_s_valid, configured); else pass_cnt++;
      tick();
      reset = 1'b0;
      cfg_e_ready = 1;
      tick();
   endtask

   task automatic test_priority();
      cfg_n_valid = 1; cfg_n_data = mk_pkt(4'd0, 4'd0, 4'b0001, 4'b0001, 2'd1, 4'd1, 32'd11);
      cfg_w_valid = 1; cfg_w_data = mk_pkt(4'd0, 4'd0, 4'b0001, 4'b0001, 2'd1, 4'd2, 32'd22);
      settle();
      total_cnt++; if ({cfg_n_ready, cfg_w_ready} !== 2'b10) $display("FAIL prio_ready got=%b exp=10", {cfg_n_ready, cfg_w_ready}); else pass_cnt++;
      tick();
      cfg_n_valid = 0;
      settle();
      total_cnt++; if ({pe_op, cfg_w_ready} !== {4'd1, 1'b1}) $display("FAIL prio_north_applied got=%0d/%b", pe_op, cfg_w_ready); else pass_cnt++;
      tick();
      cfg_w_valid = 0;
      total_cnt++; if ({pe_op, pe_imm} !== {4'd2, 32'd22}) $display("FAIL prio_west_applied got=%0d/%0d", pe_op, pe_imm); else pass_cnt++;
   endtask

   task automatic test_sel_zero();
      cfg_n_valid = 1; cfg_n_data = mk_pkt(4'd0, 4'd0, 4'b0000, 4'b0001, 2'd1, 4'd4, 32'd0);
      tick();
      cfg_n_valid = 0;
      in_valid = 4'b1111;
      tick(); tick(); tick();
      total_cnt++; if ({in_ready, pe_go, out_valid} !== 9'd0) $display("FAIL sel_zero_stall got=%b/%b/%b", in_ready, pe_go, out_valid); else pass_cnt++;
      in_valid = 0;
   endtask

   initial begin
      test_reset();
      test_route();
      test_local();
      test_bcast_stall();
      test_wrap();
      test_const_and_reset();
      test_priority();
      test_sel_zero();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
